// File: rtl/text_menu_ctrl.sv
// text_menu_ctrl
//   Navigation controller for the editor's top menu bar. It turns single-cycle
//   key pulses into a 3-bit highlighted-item selector. It issues file commands
//   over a valid/ack handshake and holds the local text-style registers.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   key_menu       pulse: open/close menu
//   key_left       pulse: previous item
//   key_right      pulse: next item
//   key_enter      pulse: execute highlighted item
//   cmd_ack        file-command consumer accepts the pending command
//   item_selector  0 = none, 1..6 = open, save, exit, caps, color, size
//   menu_active    menu open (BROWSE or WAIT_ACK)
//   cmd_valid      file command pending
//   cmd_code       1 = open, 2 = save, 3 = exit, 0 when idle
//   caps_on        caps-lock style flag
//   color_sel      text colour index, 1..7
//   size_sel       text size index, 0..3
module text_menu_ctrl #(
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int TO_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_menu,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_enter,
    input  logic       cmd_ack,
    output logic [2:0] item_selector,
    output logic       menu_active,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic       caps_on,
    output logic [2:0] color_sel,
    output logic [1:0] size_sel
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BROWSE   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic [2:0]      item_nx;
    logic            menu_active_nx;
    logic            cmd_valid_nx;
    logic [1:0]      cmd_code_nx;
    logic            caps_nx;
    logic [2:0]      color_nx;
    logic [1:0]      size_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            to_cnt        <= '0;
            item_selector <= 3'd0;
            menu_active   <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_code      <= 2'd0;
            caps_on       <= 1'b0;
            color_sel     <= 3'b111;
            size_sel      <= 2'd0;
        end else begin
            state         <= state_nx;
            to_cnt        <= to_cnt_nx;
            item_selector <= item_nx;
            menu_active   <= menu_active_nx;
            cmd_valid     <= cmd_valid_nx;
            cmd_code      <= cmd_code_nx;
            caps_on       <= caps_nx;
            color_sel     <= color_nx;
            size_sel      <= size_nx;
        end
    end

    // Next-state / next-output logic. The if/else-if chain in BROWSE encodes
    // key priority: menu > enter > right > left; lower keys are dropped.
    always_comb begin
        state_nx     = state;
        to_cnt_nx    = '0;            // held at 0 outside BROWSE and on any key
        item_nx      = item_selector;
        cmd_valid_nx = cmd_valid;
        cmd_code_nx  = cmd_code;
        caps_nx      = caps_on;
        color_nx     = color_sel;
        size_nx      = size_sel;

        case (state)
            IDLE: begin
                item_nx = 3'd0;
                if (key_menu) begin
                    state_nx = BROWSE;
                    item_nx  = 3'd1;
                end
            end

            BROWSE: begin
                if (key_menu) begin
                    state_nx = IDLE;
                    item_nx  = 3'd0;
                end else if (key_enter) begin
                    case (item_selector)
                        3'd1, 3'd2, 3'd3: begin
                            state_nx     = WAIT_ACK;
                            cmd_valid_nx = 1'b1;
                            cmd_code_nx  = item_selector[1:0];
                        end
                        3'd4:    caps_nx  = ~caps_on;
                        // colour 0 is reserved, so wrap 7 -> 1
                        3'd5:    color_nx = (color_sel == 3'd7) ? 3'd1 : color_sel + 3'd1;
                        3'd6:    size_nx  = size_sel + 2'd1;
                        default: ;
                    endcase
                end else if (key_right) begin
                    item_nx = (item_selector >= 3'd6) ? 3'd1 : item_selector + 3'd1;
                end else if (key_left) begin
                    item_nx = (item_selector <= 3'd1) ? 3'd6 : item_selector - 3'd1;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = IDLE;
                    item_nx  = 3'd0;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end

            WAIT_ACK: begin
                // keys are ignored while a command is outstanding
                if (cmd_ack) begin
                    cmd_valid_nx = 1'b0;
                    cmd_code_nx  = 2'd0;
                    if (cmd_code == 2'd3) begin
                        state_nx = IDLE;
                        item_nx  = 3'd0;
                    end else begin
                        state_nx = BROWSE;
                    end
                end
            end

            default: begin
                state_nx     = IDLE;
                item_nx      = 3'd0;
                cmd_valid_nx = 1'b0;
                cmd_code_nx  = 2'd0;
            end
        endcase

        menu_active_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_text_menu_ctrl.sv
module tb_text_menu_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_menu = 1'b0, key_left = 1'b0, key_right = 1'b0, key_enter = 1'b0;
    logic       cmd_ack = 1'b0;
    logic [2:0] item_selector;
    logic       menu_active;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       caps_on;
    logic [2:0] color_sel;
    logic [1:0] size_sel;

    typedef struct {
        logic [2:0] item;
        logic       act;
        logic       vld;
        logic [1:0] code;
        logic       caps;
        logic [2:0] color;
        logic [1:0] size;
    } exp_t;

    exp_t x;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    text_menu_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk(clk), .reset(reset),
        .key_menu(key_menu), .key_left(key_left), .key_right(key_right),
        .key_enter(key_enter), .cmd_ack(cmd_ack),
        .item_selector(item_selector), .menu_active(menu_active),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .caps_on(caps_on), .color_sel(color_sel), .size_sel(size_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".item"},  int'(item_selector), int'(e.item));
        chk({tag, ".act"},   int'(menu_active),   int'(e.act));
        chk({tag, ".vld"},   int'(cmd_valid),     int'(e.vld));
        chk({tag, ".code"},  int'(cmd_code),      int'(e.code));
        chk({tag, ".caps"},  int'(caps_on),       int'(e.caps));
        chk({tag, ".color"}, int'(color_sel),     int'(e.color));
        chk({tag, ".size"},  int'(size_sel),      int'(e.size));
    endtask

    // Output side of the scoreboard: one expectation per clock edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) chk_all("sb", sb.pop_front());
    end

    // Drive one cycle of inputs (called at negedge) and queue the outputs
    // expected after the next rising edge.
    task automatic cyc(input logic m, input logic l, input logic r,
                       input logic e, input logic a);
        key_menu = m; key_left = l; key_right = r; key_enter = e; cmd_ack = a;
        sb.push_back(x);
        @(negedge clk);
        key_menu = 0; key_left = 0; key_right = 0; key_enter = 0; cmd_ack = 0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        x = '{item: 3'd0, act: 1'b0, vld: 1'b0, code: 2'd0,
              caps: 1'b0, color: 3'd7, size: 2'd0};
        repeat (3) @(negedge clk);
        chk_all("reset", x);
        reset = 1'b1;
        @(negedge clk);

        // keys other than menu ignored in IDLE; ack ignored outside WAIT_ACK
        cyc(0, 0, 1, 1, 1);

        // open, browse right through the wrap, left wrap
        x.item = 1; x.act = 1; cyc(1, 0, 0, 0, 0);
        for (int i = 2; i <= 7; i++) begin
            x.item = (i == 7) ? 3'd1 : 3'(i);
            cyc(0, 0, 1, 0, 0);
        end
        x.item = 6; cyc(0, 1, 0, 0, 0);
        x.item = 1; cyc(0, 0, 1, 0, 0);
        x.item = 2; cyc(0, 0, 1, 0, 0);

        // save command: held through 10 cycles of ignored keys
        x.vld = 1; x.code = 2; cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1'(i == 3), 0, 1, 0, 0);
        x.vld = 0; x.code = 0; cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);  // stray ack in BROWSE

        // exit command closes the menu
        x.item = 3; cyc(0, 0, 1, 0, 0);
        x.vld = 1; x.code = 3; cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        x.vld = 0; x.code = 0; x.item = 0; x.act = 0; cyc(0, 0, 0, 0, 1);

        // style registers
        x.item = 1; x.act = 1; cyc(1, 0, 0, 0, 0);
        x.item = 6; cyc(0, 1, 0, 0, 0);
        x.item = 5; cyc(0, 1, 0, 0, 0);
        x.color = 1; cyc(0, 0, 0, 1, 0);
        x.color = 2; cyc(0, 0, 0, 1, 0);
        x.item = 6; cyc(0, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            x.size = 2'(i);
            cyc(0, 0, 0, 1, 0);
        end
        x.item = 1; cyc(0, 0, 1, 0, 0);
        x.item = 2; cyc(0, 0, 1, 0, 0);
        x.item = 3; cyc(0, 0, 1, 0, 0);
        x.item = 4; cyc(0, 0, 1, 0, 0);
        x.caps = 1; cyc(0, 0, 0, 1, 0);
        x.item = 0; x.act = 0; cyc(1, 0, 0, 0, 0);
        x.item = 1; x.act = 1; cyc(1, 0, 0, 0, 0);

        // timeout: closes exactly 16 cycles after entry
        idle_n(15);
        x.item = 0; x.act = 0; cyc(0, 0, 0, 0, 0);
        idle_n(2);

        // key in the last cycle wins and restarts the count
        x.item = 1; x.act = 1; cyc(1, 0, 0, 0, 0);
        idle_n(15);
        x.item = 2; cyc(0, 0, 1, 0, 0);
        idle_n(15);
        x.item = 0; x.act = 0; cyc(0, 0, 0, 0, 0);

        // no timeout while a command is pending
        x.item = 1; x.act = 1; cyc(1, 0, 0, 0, 0);
        x.vld = 1; x.code = 1; cyc(0, 0, 0, 1, 0);
        idle_n(40);
        x.vld = 0; x.code = 0; cyc(0, 0, 0, 0, 1);

        // priorities
        x.item = 0; x.act = 0; cyc(1, 0, 1, 0, 0);
        x.item = 1; x.act = 1; cyc(1, 0, 0, 0, 0);
        x.vld = 1; x.code = 1; cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // async reset mid-handshake
        #2;
        reset = 1'b0;
        #1;
        x = '{item: 3'd0, act: 1'b0, vld: 1'b0, code: 2'd0,
              caps: 1'b0, color: 3'd7, size: 2'd0};
        chk_all("async_rst", x);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 1);

        @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
